// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: synchronizes NSRC lines, latches/tracks them,
// masks and prioritizes (lowest ID wins) and arbitrates service via claim/complete.
module irq_ctrl #(
  parameter int          NSRC = 16,
  parameter logic [15:0] BASE = 16'h0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            io_r,
  input  logic            io_w,
  input  logic [15:0]     io_addr,
  input  logic [31:0]     io_wdata,
  output logic [31:0]     io_rdata,
  output logic            irq
);
  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [2:0] OFF_PEND   = 3'd0;
  localparam logic [2:0] OFF_ENABLE = 3'd1;
  localparam logic [2:0] OFF_EDGE   = 3'd2;
  localparam logic [2:0] OFF_CLAIM  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic [NSRC-1:0] sync_q, s_q, sd_q;
  logic [NSRC-1:0] pend_q, pend_d, en_q, en_d, edge_q, edge_d;
  logic [NSRC-1:0] cand, rise, w1c, edge_on, claim_mask, wdat;
  state_e          state_q, state_d;
  logic [4:0]      claimed_q, claimed_d, win_id;
  logic            irq_q, irq_d;
  logic            sel, rd_claim, wr_pend, wr_en, wr_edge, wr_claim, claim_ok;
  logic [2:0]      off;
  logic            unused_bits;

  assign unused_bits = ^{io_wdata[31:NSRC], io_addr[1:0]};

  assign sel      = (io_addr[15:5] == BASE[15:5]);
  assign off      = io_addr[4:2];
  assign rd_claim = io_r & sel & (off == OFF_CLAIM);
  assign wr_pend  = io_w & sel & (off == OFF_PEND);
  assign wr_en    = io_w & sel & (off == OFF_ENABLE);
  assign wr_edge  = io_w & sel & (off == OFF_EDGE);
  assign wr_claim = io_w & sel & (off == OFF_CLAIM);
  assign wdat     = io_wdata[NSRC-1:0];

  assign cand = pend_q & en_q;
  assign rise = s_q & ~sd_q;

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (cand[i]) win_id = 5'(i + 1);
  end

  assign claim_ok = rd_claim && (state_q == IDLE) && (win_id != 5'd0);

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < NSRC; i++)
      claim_mask[i] = claim_ok && (win_id == 5'(i + 1));
  end

  assign w1c     = wr_pend ? wdat : '0;
  assign edge_on = wr_edge ? (wdat & ~edge_q) : '0;

  // A fresh rising edge outranks both W1C and the claim-clear on the same bit.
  assign pend_d = ((edge_q & (rise | (pend_q & ~w1c & ~claim_mask))) |
                   (~edge_q & s_q)) & ~edge_on;
  assign en_d   = wr_en   ? wdat : en_q;
  assign edge_d = wr_edge ? wdat : edge_q;

  always_comb begin
    state_d   = state_q;
    claimed_d = claimed_q;
    case (state_q)
      IDLE: if (claim_ok) begin
        state_d   = BUSY;
        claimed_d = win_id;
      end
      BUSY: if (wr_claim && (io_wdata[4:0] == claimed_q)) begin
        state_d   = IDLE;
        claimed_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_d = (|cand) && (state_q == IDLE) && !rd_claim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      s_q       <= '0;
      sd_q      <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      edge_q    <= '0;
      state_q   <= IDLE;
      claimed_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync_q    <= src;
      s_q       <= sync_q;
      sd_q      <= s_q;
      pend_q    <= pend_d;
      en_q      <= en_d;
      edge_q    <= edge_d;
      state_q   <= state_d;
      claimed_q <= claimed_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    io_rdata = '0;
    if (io_r && sel) begin
      case (off)
        OFF_PEND:   io_rdata[NSRC-1:0] = pend_q;
        OFF_ENABLE: io_rdata[NSRC-1:0] = en_q;
        OFF_EDGE:   io_rdata[NSRC-1:0] = edge_q;
        OFF_CLAIM:  if (state_q == IDLE) io_rdata[4:0] = win_id;
        OFF_STATUS: begin
          io_rdata[4:0] = claimed_q;
          io_rdata[8]   = (state_q == BUSY);
        end
        default:    io_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed + randomized bench for irq_ctrl against a per-source behavioural model.
module tb_irq_ctrl;
  localparam int          NSRC = 16;
  localparam logic [15:0] BASE = 16'h0100;

  logic            clk, rst, io_r, io_w, irq;
  logic [NSRC-1:0] src;
  logic [15:0]     io_addr;
  logic [31:0]     io_wdata, io_rdata, last_rd;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .src(src), .io_r(io_r), .io_w(io_w),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: one entry per source, plus the handshake.
  bit m_sy1[NSRC], m_s[NSRC], m_sd[NSRC], m_pend[NSRC], m_en[NSRC], m_edg[NSRC];
  bit m_busy, m_irq;
  int m_claimed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_sy1[i] = 0; m_s[i] = 0; m_sd[i] = 0;
      m_pend[i] = 0; m_en[i] = 0; m_edg[i] = 0;
    end
    m_busy = 0; m_irq = 0; m_claimed = 0;
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_en[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [31:0] pk(input bit a[NSRC]);
    logic [31:0] v = '0;
    for (int i = 0; i < NSRC; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!io_r || io_addr[15:5] != BASE[15:5]) return 32'h0;
    case (int'(io_addr[4:2]))
      0: return pk(m_pend);
      1: return pk(m_en);
      2: return pk(m_edg);
      3: return m_busy ? 32'h0 : 32'(m_winner());
      4: return (m_busy ? 32'h100 : 32'h0) | 32'(m_claimed);
      default: return 32'h0;
    endcase
  endfunction

  // One clock: check read data before the edge, advance the model, check irq after.
  task automatic cyc();
    bit n_sy1[NSRC], n_s[NSRC], n_sd[NSRC], n_pend[NSRC], n_en[NSRC], n_edg[NSRC];
    bit n_busy, n_irq, sel, crd, cok;
    int n_cl, w, off;
    #1;
    if (!rst) m_reset();
    last_rd = io_rdata;
    chk("rdata", io_rdata, exp_rdata());
    w   = m_winner();
    sel = (io_addr[15:5] == BASE[15:5]);
    off = int'(io_addr[4:2]);
    crd = io_r && sel && off == 3;
    cok = crd && !m_busy && w != 0;
    for (int i = 0; i < NSRC; i++) begin
      n_sy1[i] = src[i]; n_s[i] = m_sy1[i]; n_sd[i] = m_s[i];
      if (m_edg[i]) begin
        if (m_s[i] && !m_sd[i])                      n_pend[i] = 1;
        else if (io_w && sel && off == 0 && io_wdata[i]) n_pend[i] = 0;
        else if (cok && w == i + 1)                  n_pend[i] = 0;
        else                                         n_pend[i] = m_pend[i];
      end else n_pend[i] = m_s[i];
      if (io_w && sel && off == 2 && io_wdata[i] && !m_edg[i]) n_pend[i] = 0;
      n_en[i]  = (io_w && sel && off == 1) ? io_wdata[i] : m_en[i];
      n_edg[i] = (io_w && sel && off == 2) ? io_wdata[i] : m_edg[i];
    end
    n_busy = m_busy; n_cl = m_claimed;
    if (cok) begin
      n_busy = 1; n_cl = w;
    end else if (io_w && sel && off == 3 && m_busy && int'(io_wdata[4:0]) == m_claimed) begin
      n_busy = 0; n_cl = 0;
    end
    n_irq = (w != 0) && !m_busy && !crd;
    @(posedge clk);
    #1;
    if (!rst) m_reset();
    else begin
      m_sy1 = n_sy1; m_s = n_s; m_sd = n_sd; m_pend = n_pend; m_en = n_en; m_edg = n_edg;
      m_busy = n_busy; m_claimed = n_cl; m_irq = n_irq;
    end
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    io_w = 1'b1; io_addr = a; io_wdata = d;
    cyc();
    io_w = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    io_r = 1'b1; io_addr = a;
    cyc();
    io_r = 1'b0;
  endtask

  initial begin
    m_reset();
    rst = 1'b0; io_r = 0; io_w = 0; io_addr = '0; io_wdata = '0;
    src = '1;

    // Reset with all lines high: everything reads 0.
    cycn(2);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    for (int o = 0; o < 8; o++) begin
      rd(BASE + 16'(o * 4));
      chk("rst_reg", last_rd, 32'h0);
    end
    rst = 1'b1;
    cycn(5);
    chk("rst_release_irq", {31'b0, irq}, 32'h0);
    src = '0;

    // Priority among edge sources 3 and 5.
    wr(BASE + 16'h08, 32'hFFFF);
    wr(BASE + 16'h04, 32'h0014);
    cycn(4);
    src = 16'h0014;
    cycn(2);
    src = '0;
    cyc();
    chk("prio_irq_e2", {31'b0, irq}, 32'h0);
    cyc();
    chk("prio_irq_e3", {31'b0, irq}, 32'h1);
    rd(BASE + 16'h0C);
    chk("prio_claim3", last_rd, 32'd3);
    chk("prio_irq_drop", {31'b0, irq}, 32'h0);
    rd(BASE + 16'h00);
    chk("prio_pend", last_rd, 32'h10);
    wr(BASE + 16'h0C, 32'd3);
    chk("prio_irq_k", {31'b0, irq}, 32'h0);
    cyc();
    chk("prio_irq_k1", {31'b0, irq}, 32'h1);
    rd(BASE + 16'h0C);
    chk("prio_claim5", last_rd, 32'd5);
    wr(BASE + 16'h0C, 32'd5);

    // Level source 1.
    wr(BASE + 16'h08, 32'h0);
    wr(BASE + 16'h04, 32'h1);
    src = 16'h0001;
    cycn(4);
    chk("lvl_irq", {31'b0, irq}, 32'h1);
    rd(BASE + 16'h0C);
    chk("lvl_claim1", last_rd, 32'd1);
    wr(BASE + 16'h0C, 32'd1);
    cyc();
    chk("lvl_reassert", {31'b0, irq}, 32'h1);
    wr(BASE + 16'h00, 32'h1);
    rd(BASE + 16'h00);
    chk("lvl_w1c_noeffect", last_rd, 32'h1);

    // Busy and mismatched completes.
    src = 16'h0002;
    wr(BASE + 16'h04, 32'h2);
    cycn(4);
    rd(BASE + 16'h0C);
    chk("busy_claim2", last_rd, 32'd2);
    rd(BASE + 16'h0C);
    chk("busy_claim_again", last_rd, 32'd0);
    rd(BASE + 16'h10);
    chk("busy_status", last_rd, 32'h102);
    wr(BASE + 16'h0C, 32'd7);
    rd(BASE + 16'h10);
    chk("mismatch_status", last_rd, 32'h102);
    wr(BASE + 16'h0C, 32'd2);
    rd(BASE + 16'h10);
    chk("done_status", last_rd, 32'h0);

    // New edge on source 2 collides with its W1C.
    src = '0;
    cycn(3);
    wr(BASE + 16'h08, 32'h2);
    cycn(2);
    src = 16'h0002;
    cycn(2);
    wr(BASE + 16'h00, 32'h2);
    rd(BASE + 16'h00);
    chk("collide_pend", last_rd, 32'h2);
    wr(BASE + 16'h00, 32'h2);
    rd(BASE + 16'h00);
    chk("w1c_pend", last_rd, 32'h0);

    // Address decode.
    wr(BASE + 16'h24, 32'hFFFF);
    wr(BASE - 16'h4, 32'hFFFF);
    rd(BASE + 16'h20);
    chk("dec_above", last_rd, 32'h0);
    rd(BASE - 16'h4);
    chk("dec_below", last_rd, 32'h0);
    rd(BASE + 16'h06);
    chk("dec_alias_en", last_rd, 32'h2);
    rd(BASE + 16'h14);
    chk("dec_reserved", last_rd, 32'h0);

    // Reset in the middle of a handshake.
    wr(BASE + 16'h08, 32'h0);
    cycn(2);
    rd(BASE + 16'h0C);
    chk("mid_claim2", last_rd, 32'd2);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    rd(BASE + 16'h10);
    chk("mid_rst_status", last_rd, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      int op;
      src = src ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2: rd(BASE + 16'($urandom_range(0, 31)));
        3:       wr(BASE + 16'h04, $urandom);
        4:       wr(BASE + 16'h08, $urandom);
        5:       wr(BASE + 16'h00, $urandom);
        6, 7:    rd(BASE + 16'h0C);
        8:       wr(BASE + 16'h0C, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31))
                                                               : 32'(m_claimed));
        9:       if ($urandom_range(0, 1) == 0) rd(16'($urandom)); else wr(16'($urandom), $urandom);
        default: cyc();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
